// File: rtl/dmem_mmio.sv
// dmem_mmio: data-side responder for the memory stage of the pipelined core.
// Reads return data in the same cycle, so the core never stalls. The address
// space holds a word-addressed data RAM and an MMIO page at 0xFFFF_xxxx:
//   0x0000 CYCLES  free-running cycle counter (writable)
//   0x0004 LEDS    16-bit LED register
//   0x0008 TXDATA  push a byte into the output FIFO (reads 0)
//   0x000C STATUS  {count, empty, full, overflow}; writing bit0=1 clears overflow
// Ports:
//   clk, reset      clock and synchronous active-low reset
//   a, wd, we       byte address, store data and store enable from the core
//   rd              combinational load data for address a
//   leds            LED register contents
//   out_valid/out_data/out_ready  valid/ready byte stream from the FIFO head
module dmem_mmio #(
    parameter int unsigned RAM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic        we,
    output logic [31:0] rd,
    output logic [15:0] leds,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready
);

    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    localparam logic [15:0] OFF_CYCLES = 16'h0000;
    localparam logic [15:0] OFF_LEDS   = 16'h0004;
    localparam logic [15:0] OFF_TXDATA = 16'h0008;
    localparam logic [15:0] OFF_STATUS = 16'h000C;

    logic [31:0]   mem_q [RAM_WORDS];
    logic [7:0]    fifo_q [FIFO_DEPTH];

    logic [31:0]   cyc_q,  cyc_d;
    logic [15:0]   leds_q, leds_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW:0]   cnt_q,  cnt_d;
    logic          ovf_q,  ovf_d;

    logic          is_mmio;
    logic [15:0]   off;
    logic [AW-1:0] ram_idx;
    logic          sel_cyc, sel_leds, sel_tx, sel_st;
    logic          full, empty, pop, push_req, push_ok;
    logic [7:0]    cnt8;

    // The byte lane bits carry no information for word-only access.
    logic          unused;
    assign unused = ^a[1:0];

    assign is_mmio  = (a[31:16] == 16'hFFFF);
    assign off      = {a[15:2], 2'b00};
    assign ram_idx  = a[AW+1:2];
    assign sel_cyc  = is_mmio && (off == OFF_CYCLES);
    assign sel_leds = is_mmio && (off == OFF_LEDS);
    assign sel_tx   = is_mmio && (off == OFF_TXDATA);
    assign sel_st   = is_mmio && (off == OFF_STATUS);

    assign full     = (cnt_q == (PW+1)'(FIFO_DEPTH));
    assign empty    = (cnt_q == '0);
    assign pop      = !empty && out_ready;
    assign push_req = we && sel_tx;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign push_ok  = push_req && (!full || pop);
    assign cnt8     = 8'(cnt_q);

    assign leds      = leds_q;
    assign out_valid = !empty;
    assign out_data  = fifo_q[rptr_q];

    always_comb begin
        rd = '0;
        if (is_mmio) begin
            case (off)
                OFF_CYCLES: rd = cyc_q;
                OFF_LEDS:   rd = {16'b0, leds_q};
                OFF_STATUS: rd = {16'b0, cnt8, 5'b0, empty, full, ovf_q};
                default:    rd = '0;
            endcase
        end else begin
            rd = mem_q[ram_idx];
        end
    end

    always_comb begin
        cyc_d  = (we && sel_cyc) ? wd : cyc_q + 32'd1;
        leds_d = (we && sel_leds) ? wd[15:0] : leds_q;
        wptr_d = push_ok ? wptr_q + PW'(1) : wptr_q;
        rptr_d = pop ? rptr_q + PW'(1) : rptr_q;
        cnt_d  = cnt_q;
        if (push_ok && !pop) begin
            cnt_d = cnt_q + (PW+1)'(1);
        end else if (!push_ok && pop) begin
            cnt_d = cnt_q - (PW+1)'(1);
        end
        ovf_d = ovf_q;
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end else if (we && sel_st && wd[0]) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cyc_q  <= '0;
            leds_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            cyc_q  <= cyc_d;
            leds_q <= leds_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    // Storage arrays are not cleared; reset only blocks writes into them.
    always_ff @(posedge clk) begin
        if (reset && we && !is_mmio) begin
            mem_q[ram_idx] <= wd;
        end
        if (reset && push_ok) begin
            fifo_q[wptr_q] <= wd[7:0];
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
module tb_dmem_mmio;

    localparam int unsigned RAM_WORDS  = 64;
    localparam int unsigned FIFO_DEPTH = 8;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] wd;
    logic        we;
    logic [31:0] rd;
    logic [15:0] leds;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] ram_m [RAM_WORDS];
    logic [31:0] cyc_m;
    logic [15:0] leds_m;
    logic [7:0]  q_m [$];
    logic        ovf_m;

    dmem_mmio #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset(reset), .a(a), .wd(wd), .we(we), .rd(rd),
        .leds(leds), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_rd(input logic [31:0] addr);
        logic [15:0] o;
        o = addr[15:0] & 16'hFFFC;
        if (addr[31:16] != 16'hFFFF) return ram_m[(addr >> 2) % RAM_WORDS];
        case (o)
            16'h0000: return cyc_m;
            16'h0004: return {16'b0, leds_m};
            16'h000C: return {16'b0, 8'(q_m.size()), 5'b0, q_m.size() == 0,
                              q_m.size() == FIFO_DEPTH, ovf_m};
            default:  return 32'h0;
        endcase
    endfunction

    // Called just after a falling edge; inputs settle well before the rising edge.
    task automatic drive(input logic [31:0] aa, input logic [31:0] ww,
                         input logic e, input logic r, input logic rs);
        a = aa; wd = ww; we = e; out_ready = r; reset = rs;
        #1;
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic tick();
        bit mm, pop, preq, acc;
        logic [15:0] o;
        logic [7:0] dropped;
        if (!reset) begin
            cyc_m = 0; leds_m = 0; q_m.delete(); ovf_m = 0;
        end else begin
            mm   = (a[31:16] == 16'hFFFF);
            o    = a[15:0] & 16'hFFFC;
            pop  = (q_m.size() != 0) && out_ready;
            preq = we && mm && o == 16'h0008;
            acc  = preq && (q_m.size() < FIFO_DEPTH || pop);
            if (pop) dropped = q_m.pop_front();
            if (acc) q_m.push_back(wd[7:0]);
            if (preq && !acc) ovf_m = 1;
            if (we && mm && o == 16'h000C && wd[0]) ovf_m = 0;
            if (we && mm && o == 16'h0000) cyc_m = wd; else cyc_m = cyc_m + 1;
            if (we && mm && o == 16'h0004) leds_m = wd[15:0];
            if (we && !mm) ram_m[(a >> 2) % RAM_WORDS] = wd;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(32'h0, 32'h0, 0, 0, 0); tick();
        drive(32'hFFFF000C, 32'h0, 0, 0, 0); tick();
        drive(32'hFFFF000C, 32'h0, 0, 0, 1);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL reset_status got %h want %h", rd, 32'h4); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++;
        if (leds !== 16'h0) begin errors++; $display("FAIL reset_leds got %h want 0", leds); end
        drive(32'hFFFF0000, 32'h0, 0, 0, 1);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_cycles got %h want 0", rd); end
    endtask

    task automatic test_ram();
        drive(32'h10, 32'h11111111, 1, 0, 1); tick();
        drive(32'h10, 32'hDEADBEEF, 1, 0, 1);
        checks++;
        if (rd !== 32'h11111111) begin errors++; $display("FAIL ram_old got %h want 11111111", rd); end
        tick();
        drive(32'h10, 32'h0, 0, 0, 1);
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_read got %h want deadbeef", rd); end
        drive(32'h110, 32'h0, 0, 0, 1);
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_alias got %h want deadbeef", rd); end
        tick();
    endtask

    task automatic test_counter();
        drive(32'h0, 32'h0, 0, 0, 0); tick();
        for (int i = 0; i < 5; i++) begin drive(32'h0, 32'h0, 0, 0, 1); tick(); end
        drive(32'hFFFF0000, 32'h0, 0, 0, 1);
        checks++;
        if (rd !== 32'd5) begin errors++; $display("FAIL cycles_5 got %h want 5", rd); end
        drive(32'hFFFF0000, 32'hFFFFFFFE, 1, 0, 1); tick();
        drive(32'hFFFF0000, 32'h0, 0, 0, 1);
        checks++;
        if (rd !== 32'hFFFFFFFE) begin errors++; $display("FAIL cycles_load got %h want fffffffe", rd); end
        tick();
        drive(32'hFFFF0000, 32'h0, 0, 0, 1);
        checks++;
        if (rd !== 32'hFFFFFFFF) begin errors++; $display("FAIL cycles_inc got %h want ffffffff", rd); end
        tick();
        drive(32'hFFFF0000, 32'h0, 0, 0, 1);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL cycles_wrap got %h want 0", rd); end
        tick();
    endtask

    task automatic test_leds();
        drive(32'hFFFF0004, 32'h1234ABCD, 1, 0, 1); tick();
        drive(32'hFFFF0004, 32'h0, 0, 0, 1);
        checks++;
        if (leds !== 16'hABCD) begin errors++; $display("FAIL leds_out got %h want abcd", leds); end
        checks++;
        if (rd !== 32'h0000ABCD) begin errors++; $display("FAIL leds_read got %h want 0000abcd", rd); end
        drive(32'hFFFF0020, 32'h0, 0, 0, 1);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL unmapped got %h want 0", rd); end
        tick();
    endtask

    task automatic test_fifo();
        logic [7:0] exp_seq [$];
        int idx;
        for (int i = 1; i <= 8; i++) begin drive(32'hFFFF0008, i, 1, 0, 1); tick(); end
        drive(32'hFFFF000C, 32'h0, 0, 0, 1);
        checks++;
        if (rd !== 32'h802) begin errors++; $display("FAIL fifo_full got %h want 802", rd); end
        tick();
        drive(32'hFFFF0008, 32'h09, 1, 0, 1); tick();
        drive(32'hFFFF000C, 32'h0, 0, 0, 1);
        checks++;
        if (rd !== 32'h803) begin errors++; $display("FAIL fifo_ovf got %h want 803", rd); end
        tick();
        drive(32'hFFFF000C, 32'h1, 1, 0, 1); tick();
        drive(32'hFFFF000C, 32'h0, 0, 0, 1);
        checks++;
        if (rd !== 32'h802) begin errors++; $display("FAIL fifo_clr got %h want 802", rd); end
        // full FIFO: push 0x55 while the head byte is popped
        drive(32'hFFFF0008, 32'h55, 1, 1, 1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h01) begin
            errors++; $display("FAIL fifo_head got %b/%h want 1/01", out_valid, out_data);
        end
        tick();
        drive(32'hFFFF000C, 32'h0, 0, 0, 1);
        checks++;
        if (rd !== 32'h802) begin errors++; $display("FAIL fifo_fullpop got %h want 802", rd); end
        exp_seq = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h55};
        idx = 0;
        for (int n = 0; n < 20 && idx < exp_seq.size(); n++) begin
            drive(32'h0, 32'h0, 0, 1, 1);
            if (out_valid === 1'b1) begin
                checks++;
                if (out_data !== exp_seq[idx]) begin
                    errors++; $display("FAIL drain_%0d got %h want %h", idx, out_data, exp_seq[idx]);
                end
                idx++;
            end
            tick();
        end
        checks++;
        if (idx != exp_seq.size()) begin errors++; $display("FAIL drain_timeout got %0d want %0d", idx, exp_seq.size()); end
        drive(32'hFFFF000C, 32'h0, 0, 0, 1);
        checks++;
        if (rd !== 32'h4 || out_valid !== 1'b0) begin
            errors++; $display("FAIL drain_empty got %h/%b want 4/0", rd, out_valid);
        end
        tick();
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 3; i++) begin drive(32'hFFFF0008, 32'hA0 + i, 1, 0, 1); tick(); end
        drive(32'hFFFF0004, 32'hFFFF, 1, 0, 1); tick();
        drive(32'hFFFF0008, 32'h77, 1, 1, 0); tick();
        drive(32'hFFFF000C, 32'h0, 0, 1, 1);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL midrst_status got %h want 4", rd); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid); end
        checks++;
        if (leds !== 16'h0) begin errors++; $display("FAIL midrst_leds got %h want 0", leds); end
        drive(32'hFFFF0000, 32'h0, 0, 1, 1);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL midrst_cyc0 got %h want 0", rd); end
        tick();
        drive(32'hFFFF0000, 32'h0, 0, 1, 1);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL midrst_cyc1 got %h want 1", rd); end
        drive(32'h10, 32'h0, 0, 1, 1);
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL midrst_ram got %h want deadbeef", rd); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addr;
        logic [15:0] offs [5] = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0020};
        for (int i = 0; i < RAM_WORDS; i++) begin
            drive(($urandom & 32'h7FFE0000) | (i * 4), $urandom, 1, 0, 1); tick();
        end
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) addr = $urandom & 32'hFFFEFFFF;
            else addr = {16'hFFFF, offs[$urandom_range(0, 4)] | 16'($urandom_range(0, 3))};
            drive(addr, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
            checks++;
            if (rd !== exp_rd(addr)) begin errors++; $display("FAIL rand_rd n=%0d a=%h got %h want %h", n, addr, rd, exp_rd(addr)); end
            checks++;
            if (out_valid !== (q_m.size() != 0)) begin errors++; $display("FAIL rand_valid n=%0d got %b want %b", n, out_valid, q_m.size() != 0); end
            if (q_m.size() != 0) begin
                checks++;
                if (out_data !== q_m[0]) begin errors++; $display("FAIL rand_data n=%0d got %h want %h", n, out_data, q_m[0]); end
            end
            checks++;
            if (leds !== leds_m) begin errors++; $display("FAIL rand_leds n=%0d got %h want %h", n, leds, leds_m); end
            tick();
        end
    endtask

    initial begin
        reset = 1'b0; a = '0; wd = '0; we = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_ram();
        test_counter();
        test_leds();
        test_fifo();
        test_reset_midop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
